reaction_round_ctrl: RTL and testbench

Parametrised round controller for the reaction minigames. It picks a pseudo-random target among `NUM_BUTTONS` inputs and runs a per-round countdown. It also judges each press as hit, miss or timeout and keeps a saturating score. It sits between the debounced/synchronised button inputs and the display and top-level game-sequencing logic.

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/round_timer.sv | 52 +++++
 rtl/reaction_round_ctrl.sv | 170 +++++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encoding and LFSR constants for the reaction round controller
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_HIT,
        ST_OVER
    } state_t;

    localparam int unsigned LFSR_W = 16;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - per-round tick prescaler and seconds down-counter with timeout strobe
module round_timer #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned ROUND_SECS    = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic       enable,
    output logic [5:0] secs_left,
    output logic       timeout
);

    localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [5:0]        secs_q, secs_d;

    always_comb begin
        tick_d  = tick_q;
        secs_d  = secs_q;
        timeout = 1'b0;
        if (load) begin
            tick_d = '0;
            secs_d = 6'(ROUND_SECS);
        end else if (enable) begin
            if (tick_q == TICK_MAX) begin
                tick_d  = '0;
                timeout = (secs_q == 6'd1);
                if (secs_q != 6'd0) begin
                    secs_d = secs_q - 6'd1;
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q <= '0;
            secs_q <= '0;
        end else begin
            tick_q <= tick_d;
            secs_q <= secs_d;
        end
    end

    assign secs_left = secs_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - reaction minigame round FSM, target LFSR and score
// Optional REACTION_LIVES_EN adds a 2-bit lives output; a game ends only when lives reach zero.
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned       NUM_BUTTONS   = 4,
    parameter int unsigned       TICKS_PER_SEC = 50000000,
    parameter int unsigned       ROUND_SECS    = 5,
    parameter int unsigned       SCORE_W       = 7,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] target,
    output logic [5:0]             secs_left,
    output logic [SCORE_W-1:0]     score,
    output logic                   hit,
    output logic                   miss,
    output logic                   game_over,
    output logic                   busy
`ifdef REACTION_LIVES_EN
    ,
    output logic [1:0]             lives
`endif
);

`ifdef REACTION_LIVES_EN
    localparam logic [1:0] LIVES_INIT = 2'd3;
    logic [1:0] lives_q, lives_d;
`endif

    state_t                   state_q, state_d;
    logic [LFSR_W-1:0]        lfsr_q, lfsr_d;
    logic [NUM_BUTTONS-1:0]   prev_q, rise, pick;
    logic [NUM_BUTTONS-1:0]   target_q, target_d;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic                     hit_q, hit_d, miss_q, miss_d;
    logic                     over_q, over_d, busy_q, busy_d;
    logic                     timer_load, timer_en, timeout;
    logic [4:0]               idx;

    assign rise   = buttons & ~prev_q;
    assign lfsr_d = lfsr_next(lfsr_q);

    // Single conditional subtract; indices still past the button count give an all-zero pick
    always_comb begin
        idx = {1'b0, lfsr_q[3:0]};
        if (idx >= 5'(NUM_BUTTONS)) begin
            idx = idx - 5'(NUM_BUTTONS);
        end
        pick = {{(NUM_BUTTONS-1){1'b0}}, 1'b1} << idx;
    end

    // Any press this cycle freezes the countdown, so a hit on the final tick beats the timeout
    assign timer_en = (state_q == ST_WAIT) && (rise == '0);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        score_d    = score_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        timer_load = 1'b0;
`ifdef REACTION_LIVES_EN
        lives_d    = lives_q;
`endif
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_ARM;
                    score_d = '0;
`ifdef REACTION_LIVES_EN
                    lives_d = LIVES_INIT;
`endif
                end
            end
            ST_ARM: begin
                if (buttons == '0) begin
                    target_d   = pick;
                    timer_load = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((rise != '0) || timeout) begin
                    target_d = '0;
                    if ((rise != '0) && (rise == target_q)) begin
                        hit_d   = 1'b1;
                        state_d = ST_HIT;
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end else begin
                        miss_d = 1'b1;
`ifdef REACTION_LIVES_EN
                        if (lives_q <= 2'd1) begin
                            lives_d = 2'd0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d = lives_q - 2'd1;
                            state_d = ST_ARM;
                        end
`else
                        state_d = ST_OVER;
`endif
                    end
                end
            end
            ST_HIT:  state_d = ST_ARM;
            default: state_d = ST_IDLE;
        endcase
        over_d = (state_d == ST_OVER);
        busy_d = (state_d == ST_ARM) || (state_d == ST_WAIT) || (state_d == ST_HIT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_SEED;
            prev_q   <= '0;
            target_q <= '0;
            score_q  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            over_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef REACTION_LIVES_EN
            lives_q  <= LIVES_INIT;
`endif
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            prev_q   <= buttons;
            target_q <= target_d;
            score_q  <= score_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            over_q   <= over_d;
            busy_q   <= busy_d;
`ifdef REACTION_LIVES_EN
            lives_q  <= lives_d;
`endif
        end
    end

    round_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .ROUND_SECS   (ROUND_SECS)
    ) u_round_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (timer_load),
        .enable   (timer_en),
        .secs_left(secs_left),
        .timeout  (timeout)
    );

    assign target    = target_q;
    assign score     = score_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign game_over = over_q;
    assign busy      = busy_q;
`ifdef REACTION_LIVES_EN
    assign lives     = lives_q;
`endif

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb/tb_reaction_round_ctrl.sv - self-checking bench for reaction_round_ctrl (default and REACTION_LIVES_EN builds)
module tb_reaction_round_ctrl;

    localparam int NB  = 4;
    localparam int TPS = 4;
    localparam int RS  = 2;
    localparam int SW  = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int M_IDLE = 0, M_ARM = 1, M_WAIT = 2, M_HIT = 3, M_OVER = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [NB-1:0] buttons = '0;
    logic [NB-1:0] target;
    logic [5:0]    secs_left;
    logic [SW-1:0] score;
    logic          hit, miss, game_over, busy;
`ifdef REACTION_LIVES_EN
    logic [1:0]    lives;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reaction_round_ctrl #(
        .NUM_BUTTONS  (NB),
        .TICKS_PER_SEC(TPS),
        .ROUND_SECS   (RS),
        .SCORE_W      (SW),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .buttons  (buttons),
        .target   (target),
        .secs_left(secs_left),
        .score    (score),
        .hit      (hit),
        .miss     (miss),
        .game_over(game_over),
        .busy     (busy)
`ifdef REACTION_LIVES_EN
        ,
        .lives    (lives)
`endif
    );

    // Reference model: rounds measured in elapsed cycles, scores and lives as plain integers
    int            m_st = M_IDLE;
    logic [15:0]   m_lfsr = SEED;
    logic [NB-1:0] m_prev = '0, m_target = '0, m_rise;
    int            m_cyc = 0, m_secs = 0, m_score = 0, m_lives = 3, m_i;
    bit            m_hit = 1'b0, m_miss = 1'b0;

    function automatic int pick_idx(input logic [15:0] l);
        int i = int'(l[3:0]);
        if (i >= NB) i -= NB;
        return i;
    endfunction

    task automatic model_miss();
        m_miss   = 1'b1;
        m_target = '0;
`ifdef REACTION_LIVES_EN
        m_lives = m_lives - 1;
        m_st    = (m_lives == 0) ? M_OVER : M_ARM;
`else
        m_st = M_OVER;
`endif
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_st = M_IDLE; m_lfsr = SEED; m_prev = '0; m_target = '0;
            m_cyc = 0; m_secs = 0; m_score = 0; m_lives = 3; m_hit = 1'b0; m_miss = 1'b0;
        end else begin
            m_rise = buttons & ~m_prev;
            m_hit  = 1'b0;
            m_miss = 1'b0;
            case (m_st)
                M_IDLE, M_OVER: if (start) begin m_st = M_ARM; m_score = 0; m_lives = 3; end
                M_ARM: if (buttons == '0) begin
                    m_i      = pick_idx(m_lfsr);
                    m_target = (m_i < NB) ? NB'(1 << m_i) : '0;
                    m_cyc    = 0;
                    m_secs   = RS;
                    m_st     = M_WAIT;
                end
                M_WAIT: begin
                    if (m_rise != '0) begin
                        if ($countones(m_rise) == 1 && m_rise == m_target) begin
                            m_hit    = 1'b1;
                            m_score  = (m_score < (1 << SW) - 1) ? m_score + 1 : m_score;
                            m_target = '0;
                            m_st     = M_HIT;
                        end else begin
                            model_miss();
                        end
                    end else begin
                        m_cyc  = m_cyc + 1;
                        m_secs = RS - m_cyc / TPS;
                        if (m_cyc == RS * TPS) model_miss();
                    end
                end
                M_HIT: m_st = M_ARM;
                default: ;
            endcase
            m_prev = buttons;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Hold a button in ARM until the model LFSR yields an in-range target, then release
    task automatic goto_wait();
        int guard = 0;
        while (m_st != M_WAIT && guard < 64) begin
            buttons = (m_st == M_ARM && pick_idx(m_lfsr) < NB) ? '0 : NB'(1);
            tick();
            guard++;
        end
        buttons = '0;
        n_assert++;
        if (m_st != M_WAIT) begin
            n_fail++;
            $display("FAIL goto_wait: model state %0d after %0d cycles, required %0d", m_st, guard, M_WAIT);
        end
    endtask

    task automatic finish_game();
        for (int k = 0; k < 4 && m_st != M_OVER; k++) begin
            goto_wait();
            buttons = {m_target[NB-2:0], m_target[NB-1]};
            tick();
            buttons = '0;
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        n_assert++; if (target !== '0)    begin n_fail++; $display("FAIL reset_target got=%h exp=0", target); end
        n_assert++; if (secs_left !== '0) begin n_fail++; $display("FAIL reset_secs got=%0d exp=0", secs_left); end
        n_assert++; if (score !== '0)     begin n_fail++; $display("FAIL reset_score got=%0d exp=0", score); end
        n_assert++; if (hit !== 1'b0 || miss !== 1'b0) begin n_fail++; $display("FAIL reset_pulses hit=%b miss=%b exp=0,0", hit, miss); end
        n_assert++; if (game_over !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags go=%b busy=%b exp=0,0", game_over, busy); end
        n_assert++; if (dut.lfsr_q !== SEED) begin n_fail++; $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr_q, SEED); end
`ifdef REACTION_LIVES_EN
        n_assert++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives got=%0d exp=3", lives); end
`endif
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_correct_press();
        logic [NB-1:0] t;
        start = 1'b1; tick(); start = 1'b0;
        n_assert++; if (busy !== 1'b1 || target !== '0) begin n_fail++; $display("FAIL start_arm busy=%b target=%h exp=1,0", busy, target); end
        goto_wait();
        t = m_target;
        n_assert++; if (target !== t || $countones(target) != 1) begin n_fail++; $display("FAIL first_target got=%h exp=%h", target, t); end
        buttons = t; tick();
        n_assert++; if (hit !== 1'b1 || miss !== 1'b0) begin n_fail++; $display("FAIL hit_pulse hit=%b miss=%b exp=1,0", hit, miss); end
        n_assert++; if (score !== SW'(1) || target !== '0) begin n_fail++; $display("FAIL hit_score score=%0d target=%h exp=1,0", score, target); end
        tick();
        n_assert++; if (hit !== 1'b0 || target !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL after_hit hit=%b target=%h busy=%b exp=0,0,1", hit, target, busy); end
        goto_wait();
        n_assert++; if (target !== m_target || $countones(target) != 1) begin n_fail++; $display("FAIL next_target got=%h exp=%h", target, m_target); end
    endtask

    task automatic test_wrong_press();
        buttons = {m_target[NB-2:0], m_target[NB-1]};
        tick();
        n_assert++; if (miss !== 1'b1 || hit !== 1'b0) begin n_fail++; $display("FAIL wrong_miss miss=%b hit=%b exp=1,0", miss, hit); end
        n_assert++; if (score !== SW'(1) || target !== '0) begin n_fail++; $display("FAIL wrong_hold score=%0d target=%h exp=1,0", score, target); end
`ifdef REACTION_LIVES_EN
        n_assert++; if (game_over !== 1'b0 || lives !== 2'd2) begin n_fail++; $display("FAIL wrong_lives go=%b lives=%0d exp=0,2", game_over, lives); end
`else
        n_assert++; if (game_over !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wrong_over go=%b busy=%b exp=1,0", game_over, busy); end
`endif
        buttons = '0;
        tick();
    endtask

    task automatic test_timeout();
        int exp_lives;
        if (m_st == M_OVER || m_st == M_IDLE) begin start = 1'b1; tick(); start = 1'b0; end
        goto_wait();
        exp_lives = m_lives - 1;
        for (int k = 0; k < RS * TPS; k++) begin
            n_assert++;
            if (secs_left !== 6'(RS - k / TPS) || miss !== 1'b0) begin
                n_fail++; $display("FAIL countdown k=%0d secs=%0d miss=%b exp=%0d,0", k, secs_left, miss, RS - k / TPS);
            end
            tick();
        end
        n_assert++; if (miss !== 1'b1 || secs_left !== 6'd0 || target !== '0) begin n_fail++; $display("FAIL timeout miss=%b secs=%0d target=%h exp=1,0,0", miss, secs_left, target); end
`ifdef REACTION_LIVES_EN
        n_assert++; if (lives !== 2'(exp_lives) || game_over !== (exp_lives == 0)) begin n_fail++; $display("FAIL timeout_lives lives=%0d go=%b exp=%0d", lives, game_over, exp_lives); end
`else
        n_assert++; if (game_over !== 1'b1 || exp_lives != 2) begin n_fail++; $display("FAIL timeout_over go=%b exp=1", game_over); end
`endif
        tick();
        n_assert++; if (miss !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse miss=%b exp=0", miss); end
    endtask

    task automatic test_double_press();
        int s0;
        if (m_st == M_OVER || m_st == M_IDLE) begin start = 1'b1; tick(); start = 1'b0; end
        goto_wait();
        s0 = m_score;
        buttons = m_target | {m_target[NB-2:0], m_target[NB-1]};
        tick();
        n_assert++; if (miss !== 1'b1 || hit !== 1'b0) begin n_fail++; $display("FAIL double miss=%b hit=%b exp=1,0", miss, hit); end
        n_assert++; if (score !== SW'(s0)) begin n_fail++; $display("FAIL double_score got=%0d exp=%0d", score, s0); end
        buttons = '0;
        tick();
    endtask

    task automatic test_saturation();
        finish_game();
        start = 1'b1; tick(); start = 1'b0;
        n_assert++; if (score !== '0 || busy !== 1'b1 || game_over !== 1'b0) begin n_fail++; $display("FAIL restart1 score=%0d busy=%b go=%b exp=0,1,0", score, busy, game_over); end
        for (int r = 1; r <= 5; r++) begin
            goto_wait();
            buttons = m_target;
            tick();
            n_assert++;
            if (hit !== 1'b1 || score !== SW'((r < 3) ? r : 3)) begin
                n_fail++; $display("FAIL sat_round %0d hit=%b score=%0d exp=1,%0d", r, hit, score, (r < 3) ? r : 3);
            end
            buttons = '0;
            tick();
        end
        finish_game();
        n_assert++; if (game_over !== 1'b1 || score !== SW'(3)) begin n_fail++; $display("FAIL sat_hold go=%b score=%0d exp=1,3", game_over, score); end
        start = 1'b1; tick(); start = 1'b0;
        n_assert++; if (score !== '0 || busy !== 1'b1 || target !== '0 || game_over !== 1'b0) begin n_fail++; $display("FAIL restart2 score=%0d busy=%b target=%h go=%b exp=0,1,0,0", score, busy, target, game_over); end
    endtask

    task automatic test_mid_reset();
        if (m_st == M_OVER || m_st == M_IDLE) begin start = 1'b1; tick(); start = 1'b0; end
        goto_wait();
        repeat (2) tick();
        #2 resetn = 1'b0;
        #1;
        n_assert++;
        if (target !== '0 || secs_left !== '0 || score !== '0 || hit !== 1'b0 || miss !== 1'b0 || game_over !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset t=%h s=%0d sc=%0d h=%b m=%b go=%b b=%b exp all 0", target, secs_left, score, hit, miss, game_over, busy);
        end
        tick();
        resetn = 1'b1;
        n_assert++; if (dut.lfsr_q !== SEED) begin n_fail++; $display("FAIL mid_reset_lfsr got=%h exp=%h", dut.lfsr_q, SEED); end
        tick();
        n_assert++; if (busy !== 1'b0 || game_over !== 1'b0) begin n_fail++; $display("FAIL mid_reset_idle busy=%b go=%b exp=0,0", busy, game_over); end
    endtask

    task automatic test_random();
        int r;
        bit bad;
        for (int c = 0; c < 800; c++) begin
            r = $urandom_range(0, 99);
            start = (r < 4);
            if (r < 55)      buttons = '0;
            else if (r < 80) buttons = m_target;
            else if (r < 90) buttons = buttons;
            else             buttons = NB'($urandom);
            tick();
            bad = (target !== m_target) || (secs_left !== 6'(m_secs)) || (score !== SW'(m_score)) ||
                  (hit !== m_hit) || (miss !== m_miss) || (game_over !== (m_st == M_OVER)) ||
                  (busy !== (m_st == M_ARM || m_st == M_WAIT || m_st == M_HIT));
`ifdef REACTION_LIVES_EN
            bad = bad || (lives !== 2'(m_lives));
`endif
            n_assert++;
            if (bad) begin
                n_fail++;
                $display("FAIL random c=%0d got t=%h s=%0d sc=%0d h=%b m=%b go=%b b=%b exp t=%h s=%0d sc=%0d h=%b m=%b st=%0d",
                         c, target, secs_left, score, hit, miss, game_over, busy, m_target, m_secs, m_score, m_hit, m_miss, m_st);
            end
        end
        buttons = '0;
        start   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_correct_press();
        test_wrong_press();
        test_timeout();
        test_double_press();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
